// File: rtl/sap1_accumulator_unit.sv
// SAP-1 accumulator/B-register stage around the adder_subtracter.
// Sequences ADD/SUB from a single start pulse and captures carry/zero flags.
module sap1_accumulator_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] w_bus_in,
    input  logic             la,
    input  logic             lb,
    input  logic             ea,
    input  logic             start,
    input  logic             sub_req,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_carry,
    output logic [WIDTH-1:0] a_to_alu,
    output logic [WIDTH-1:0] b_to_alu,
    output logic             SUB,
    output logic [WIDTH-1:0] acc_out,
    output logic             acc_oe,
    output logic             eu,
    output logic             busy,
    output logic             done,
    output logic             flag_c,
    output logic             flag_z
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             sub_r;
    logic             idle;

    assign idle = (state == ST_IDLE);

    // Next-state: IDLE -> EXEC on start, EXEC and DONE last one cycle each
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator: direct loads only while idle and not starting; EXEC writes back
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            reg_a <= '0;
        end else if (state == ST_EXEC) begin
            reg_a <= alu_s;
        end else if (idle && !start && la) begin
            reg_a <= w_bus_in;
        end
    end

    // B register and op select: start captures the operand and op together
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            reg_b <= '0;
            sub_r <= 1'b0;
        end else if (idle) begin
            if (start) begin
                reg_b <= w_bus_in;
                sub_r <= sub_req;
            end else if (lb) begin
                reg_b <= w_bus_in;
            end
        end
    end

    // Flags move only on the EXEC writeback
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (state == ST_EXEC) begin
            flag_c <= alu_carry;
            flag_z <= (alu_s == '0);
        end
    end

    assign a_to_alu = reg_a;
    assign acc_out  = reg_a;
    assign b_to_alu = reg_b;
    assign SUB      = sub_r;
    assign acc_oe   = ea & idle;
    assign eu       = (state == ST_EXEC);
    assign busy     = !idle;
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_sap1_accumulator_unit.sv
// Scoreboard bench for sap1_accumulator_unit with a behavioural adder.
// Expected A/flags are queued at start and checked on the done pulse.
module tb_sap1_accumulator_unit;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic         c;
        logic         z;
    } res_t;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic [W-1:0] w_bus_in = '0;
    logic         la = 1'b0;
    logic         lb = 1'b0;
    logic         ea = 1'b0;
    logic         start = 1'b0;
    logic         sub_req = 1'b0;
    logic [W-1:0] alu_s;
    logic         alu_carry;
    logic [W-1:0] a_to_alu;
    logic [W-1:0] b_to_alu;
    logic         SUB;
    logic [W-1:0] acc_out;
    logic         acc_oe;
    logic         eu;
    logic         busy;
    logic         done;
    logic         flag_c;
    logic         flag_z;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb_q[$];
    logic [W-1:0] model_a = '0;

    always #5 clk = ~clk;

    // External adder_subtracter
    always_comb begin
        logic [W:0] sum;
        if (SUB) sum = {1'b0, a_to_alu} + {1'b0, ~b_to_alu} + 9'd1;
        else     sum = {1'b0, a_to_alu} + {1'b0, b_to_alu};
        alu_s     = sum[W-1:0];
        alu_carry = sum[W];
    end

    sap1_accumulator_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .w_bus_in  (w_bus_in),
        .la        (la),
        .lb        (lb),
        .ea        (ea),
        .start     (start),
        .sub_req   (sub_req),
        .alu_s     (alu_s),
        .alu_carry (alu_carry),
        .a_to_alu  (a_to_alu),
        .b_to_alu  (b_to_alu),
        .SUB       (SUB),
        .acc_out   (acc_out),
        .acc_oe    (acc_oe),
        .eu        (eu),
        .busy      (busy),
        .done      (done),
        .flag_c    (flag_c),
        .flag_z    (flag_z)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_a(input logic [W-1:0] v);
        @(negedge clk);
        la = 1'b1;
        w_bus_in = v;
        @(negedge clk);
        la = 1'b0;
        model_a = v;
        check("la_load", a_to_alu, v);
    endtask

    task automatic do_op(input logic [W-1:0] bus, input logic s,
                         input logic intrude);
        logic [W:0] sum;
        res_t       r;
        res_t       e;
        bit         seen;
        @(negedge clk);
        start = 1'b1;
        sub_req = s;
        w_bus_in = bus;
        if (s) sum = {1'b0, model_a} + {1'b0, ~bus} + 9'd1;
        else   sum = {1'b0, model_a} + {1'b0, bus};
        r.a = sum[W-1:0];
        r.c = sum[W];
        r.z = (sum[W-1:0] == '0);
        sb_q.push_back(r);
        @(posedge clk);
        #1;
        start = 1'b0;
        sub_req = 1'b0;
        if (intrude) begin
            la = 1'b1;
            ea = 1'b1;
            w_bus_in = 8'hAA;
        end
        seen = 1'b0;
        for (int cyc = 1; cyc <= 6 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("exec_eu", eu, 1'b1);
                check("exec_sub", SUB, s);
                check("exec_busy", busy, 1'b1);
                check("exec_done", done, 1'b0);
                if (intrude) check("exec_oe", acc_oe, 1'b0);
            end
            if (done) begin
                seen = 1'b1;
                check("done_lat", cyc, 2);
                if (intrude) check("done_oe", acc_oe, 1'b0);
                e = sb_q.pop_front();
                check("res_a", a_to_alu, e.a);
                check("res_c", flag_c, e.c);
                check("res_z", flag_z, e.z);
                model_a = e.a;
                la = 1'b0;
                ea = 1'b0;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            void'(sb_q.pop_front());
            la = 1'b0;
            ea = 1'b0;
        end
        @(negedge clk);
        check("done_1cyc", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("hold_a", a_to_alu, model_a);
    endtask

    initial begin
        #12;
        check("rst_a", a_to_alu, 0);
        check("rst_b", b_to_alu, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sub", SUB, 0);
        check("rst_flags", {flag_c, flag_z}, 0);
        @(negedge clk);
        clr_n = 1'b1;

        load_a(8'h01);
        do_op(8'h02, 1'b0, 1'b0);
        do_op(8'h01, 1'b1, 1'b0);
        load_a(8'h8A);
        do_op(8'h05, 1'b1, 1'b0);
        load_a(8'h05);
        do_op(8'h05, 1'b1, 1'b0);
        load_a(8'hFF);
        do_op(8'h01, 1'b0, 1'b0);
        load_a(8'h10);
        check("la_keeps_flags", {flag_c, flag_z}, 2'b11);
        do_op(8'h20, 1'b0, 1'b1);

        @(negedge clk);
        ea = 1'b1;
        #1;
        check("idle_oe", acc_oe, 1'b1);
        check("idle_acc_out", acc_out, model_a);
        ea = 1'b0;

        @(negedge clk);
        lb = 1'b1;
        w_bus_in = 8'h44;
        @(negedge clk);
        lb = 1'b0;
        check("lb_load", b_to_alu, 8'h44);
        check("lb_keeps_a", a_to_alu, model_a);
        la = 1'b1;
        lb = 1'b1;
        w_bus_in = 8'h5C;
        @(negedge clk);
        la = 1'b0;
        lb = 1'b0;
        model_a = 8'h5C;
        check("lab_a", a_to_alu, 8'h5C);
        check("lab_b", b_to_alu, 8'h5C);

        load_a(8'h01);
        do_op(8'h02, 1'b1, 1'b0);

        // Asynchronous reset in the middle of EXEC
        @(negedge clk);
        start = 1'b1;
        w_bus_in = 8'h33;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("pre_rst_eu", eu, 1'b1);
        #2;
        clr_n = 1'b0;
        #1;
        check("arst_a", a_to_alu, 0);
        check("arst_b", b_to_alu, 0);
        check("arst_flags", {flag_c, flag_z}, 0);
        check("arst_busy", busy, 0);
        model_a = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", done, 0);
        end
        clr_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", done, 0);
        do_op(8'h07, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
